// File: rtl/intdivrem_iter.sv
// intdivrem_iter: iterative RV M-extension divide/remainder unit (DIV/DIVU/REM/REMU + W forms).
// Restoring division on magnitudes, K quotient bits per cycle, Busy/Done/Stall/Flush handshake.
// Optional macro IDIV_EARLYTERM_EN: skip leading-zero digits of |A| to shorten the iteration count.
module intdivrem_iter #(
  parameter int XLEN = 64,
  parameter int K    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic            FlushE,
  input  logic            StallM,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultM
);

  localparam int unsigned XU  = XLEN;
  localparam int unsigned KU  = K;
  localparam int unsigned NIT = XU / KU;
  localparam int unsigned CW  = $clog2(NIT + 1);
  localparam bit          HAS_W = (XLEN > 32);
  localparam logic [XLEN-1:0] MINV  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   NIT_C = CW'(NIT);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_POST, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a, r_b, r_dvd, r_dsr, r_result;
  logic [XLEN:0]   r_rem;
  logic            r_unsigned, r_remop, r_w, r_negq, r_negr, r_busy, r_done;

  logic            w_w, w_nega, w_negb, w_b_zero, w_ovf;
  logic [XLEN-1:0] w_a_eff, w_b_eff, w_maga, w_magb, w_dvd_init;
  logic [XLEN-1:0] w_spec_raw, w_spec_res, w_quo, w_rmd, w_post_raw, w_post_res;
  logic [CW-1:0]   w_iters;
  logic [XLEN:0]   w_step_rem, w_rem_nx;
  logic [XLEN-1:0] w_step_dvd, w_step_dsr, w_dvd_nx;
  logic [XLEN+1:0] w_diff;
  logic            w_unused_f3;

  // Replace bits above 31 with s (word-op operand/result extension)
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic s);
    logic [XLEN-1:0] y;
    y = x;
    for (int unsigned i = 32; i < XU; i++) y[i] = s;
    return y;
  endfunction

  assign w_unused_f3 = Funct3E[2];
  assign w_w         = HAS_W & r_w;

  // Operand conditioning: effective-width extension, magnitudes, special-case detection
  always_comb begin
    w_a_eff    = w_w ? ext32(r_a, ~r_unsigned & r_a[31]) : r_a;
    w_b_eff    = w_w ? ext32(r_b, ~r_unsigned & r_b[31]) : r_b;
    w_nega     = ~r_unsigned & w_a_eff[XLEN-1];
    w_negb     = ~r_unsigned & w_b_eff[XLEN-1];
    w_maga     = w_nega ? -w_a_eff : w_a_eff;
    w_magb     = w_negb ? -w_b_eff : w_b_eff;
    w_b_zero   = (w_b_eff == '0);
    w_ovf      = ~r_unsigned & (w_w ? (r_a[31:0] == 32'h8000_0000 && r_b[31:0] == 32'hFFFF_FFFF)
                                    : (w_a_eff == MINV && w_b_eff == '1));
    w_spec_raw = w_b_zero ? (r_remop ? w_a_eff : '1) : (r_remop ? '0 : w_a_eff);
    w_spec_res = w_w ? ext32(w_spec_raw, w_spec_raw[31]) : w_spec_raw;
  end

`ifdef IDIV_EARLYTERM_EN
  localparam int unsigned LZW = $clog2(XU + 1);
  logic [LZW-1:0] w_lz;

  // Leading-zero count of |A| rounded down to a digit boundary, and the shortened iteration count
  always_comb begin
    int unsigned v_lzc, v_lz, v_it;
    v_lzc = XU;
    for (int unsigned i = 0; i < XU; i++) if (w_maga[i]) v_lzc = XU - 1 - i;
    v_lz  = (v_lzc / KU) * KU;
    v_it  = (XU - v_lz) / KU;
    if (v_it == 0) v_it = 1;
    w_lz       = v_lz[LZW-1:0];
    w_iters    = v_it[CW-1:0];
    w_dvd_init = w_maga << w_lz;
  end
`else
  assign w_iters    = NIT_C;
  assign w_dvd_init = w_maga;
`endif

  // The first digit is produced in PREP so ITER needs one cycle fewer than the iteration count
  assign w_step_rem = (r_state == S_PREP) ? '0         : r_rem;
  assign w_step_dvd = (r_state == S_PREP) ? w_dvd_init : r_dvd;
  assign w_step_dsr = (r_state == S_PREP) ? w_magb     : r_dsr;

  // K chained restoring sub-steps; quotient bits shift into the dividend register LSB
  always_comb begin
    w_rem_nx = w_step_rem;
    w_dvd_nx = w_step_dvd;
    w_diff   = '0;
    for (int unsigned s = 0; s < KU; s++) begin
      w_rem_nx = {w_rem_nx[XLEN-1:0], w_dvd_nx[XLEN-1]};
      w_dvd_nx = {w_dvd_nx[XLEN-2:0], 1'b0};
      w_diff   = {1'b0, w_rem_nx} - {2'b00, w_step_dsr};
      if (!w_diff[XLEN+1]) begin
        w_rem_nx    = w_diff[XLEN:0];
        w_dvd_nx[0] = 1'b1;
      end
    end
  end

  // Sign fix-up and word-result extension
  always_comb begin
    w_quo      = r_negq ? -r_dvd : r_dvd;
    w_rmd      = r_negr ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    w_post_raw = r_remop ? w_rmd : w_quo;
    w_post_res = w_w ? ext32(w_post_raw, w_post_raw[31]) : w_post_raw;
  end

  // Control FSM with registered Busy/Done/Result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE; r_cnt <= '0;
      r_a <= '0; r_b <= '0; r_dvd <= '0; r_dsr <= '0; r_rem <= '0; r_result <= '0;
      r_unsigned <= 1'b0; r_remop <= 1'b0; r_w <= 1'b0; r_negq <= 1'b0; r_negr <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (StartE && !FlushE) begin
          r_a        <= ForwardedSrcAE;
          r_b        <= ForwardedSrcBE;
          r_unsigned <= Funct3E[0];
          r_remop    <= Funct3E[1];
          r_w        <= W64E;
          r_busy     <= 1'b1;
          r_state    <= S_PREP;
        end
        S_PREP: if (FlushE) begin
          r_busy <= 1'b0; r_state <= S_IDLE;
        end else if (w_b_zero || w_ovf) begin
          r_result <= w_spec_res; r_done <= 1'b1; r_state <= S_DONE;
        end else begin
          r_rem   <= w_rem_nx;
          r_dvd   <= w_dvd_nx;
          r_dsr   <= w_magb;
          r_negq  <= w_nega ^ w_negb;
          r_negr  <= w_nega;
          r_cnt   <= w_iters - CW'(1);
          r_state <= (w_iters == CW'(1)) ? S_POST : S_ITER;
        end
        S_ITER: if (FlushE) begin
          r_busy <= 1'b0; r_state <= S_IDLE;
        end else begin
          r_rem <= w_rem_nx;
          r_dvd <= w_dvd_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_POST;
        end
        S_POST: if (FlushE) begin
          r_busy <= 1'b0; r_state <= S_IDLE;
        end else begin
          r_result <= w_post_res; r_done <= 1'b1; r_state <= S_DONE;
        end
        S_DONE: if (FlushE || !StallM) begin
          r_busy <= 1'b0; r_done <= 1'b0; r_state <= S_IDLE;
        end
        default: begin
          r_busy <= 1'b0; r_done <= 1'b0; r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BusyE   = r_busy;
  assign DoneE   = r_done;
  assign ResultM = r_result;

endmodule
